// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter/rotator: one mux stage per shift-amount bit, global stall.
// Optional carry-out tap (out_cout) is built only when BARREL_COUT_EN is defined.
module barrel_shift_pipe #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef BARREL_COUT_EN
  ,
  output logic             out_cout
`endif
);

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_ROR = 2'b01;
  localparam logic [1:0] OP_LSL = 2'b10;
  localparam logic [1:0] OP_ASR = 2'b11;

  logic adv;

  function automatic logic [WIDTH-1:0] move_stage(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       op,
    input logic             sign,
    input int               s
  );
    logic [WIDTH-1:0] fill;
    fill = {WIDTH{sign}} << (WIDTH - s);
    case (op)
      OP_ROL:  move_stage = (d << s) | (d >> (WIDTH - s));
      OP_ROR:  move_stage = (d >> s) | (d << (WIDTH - s));
      OP_LSL:  move_stage = d << s;
      OP_ASR:  move_stage = (d >> s) | fill;
      default: move_stage = d;
    endcase
  endfunction

`ifdef BARREL_COUT_EN
  // The last bit leaving the word in a move of s: d[s-1] going right, d[WIDTH-s] going left.
  function automatic logic move_cout(
    input logic [WIDTH-1:0] d,
    input logic             right,
    input int               s
  );
    logic [WIDTH-1:0] t;
    if (right) begin
      t = d >> (s - 1);
    end else begin
      t = d >> (WIDTH - s);
    end
    move_cout = t[0];
  endfunction
`endif

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int MOVE = 1 << k;

    logic                 src_vld;
    logic [WIDTH-1:0]     src_data;
    logic [SHW-k-1:0]     src_rem;
    logic [1:0]           src_op;
    logic                 src_sign;
    logic                 vld_d, vld_q;
    logic [WIDTH-1:0]     data_d, data_q;
`ifdef BARREL_COUT_EN
    logic                 src_cout;
    logic                 cout_d, cout_q;
`endif

    // src_rem[0] is this stage's amount bit; the upper bits travel on to later stages.
    if (k == 0) begin : g_src
      assign src_vld  = in_valid;
      assign src_data = in_data;
      assign src_rem  = in_amt;
      assign src_op   = in_op;
      assign src_sign = in_data[WIDTH-1];
`ifdef BARREL_COUT_EN
      assign src_cout = 1'b0;
`endif
    end else begin : g_src
      assign src_vld  = g_stage[k-1].vld_q;
      assign src_data = g_stage[k-1].data_q;
      assign src_rem  = g_stage[k-1].g_meta.rem_q;
      assign src_op   = g_stage[k-1].g_meta.op_q;
      assign src_sign = g_stage[k-1].g_meta.sign_q;
`ifdef BARREL_COUT_EN
      assign src_cout = g_stage[k-1].cout_q;
`endif
    end

    // Bubbles clear the valid bit but leave the old payload in place.
    always_comb begin
      vld_d  = vld_q;
      data_d = data_q;
      if (adv) begin
        vld_d = src_vld;
        if (src_vld && src_rem[0]) begin
          data_d = move_stage(src_data, src_op, src_sign, MOVE);
        end else if (src_vld) begin
          data_d = src_data;
        end else begin
          data_d = data_q;
        end
      end else begin
        vld_d = vld_q;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q  <= 1'b0;
        data_q <= {WIDTH{1'b0}};
      end else begin
        vld_q  <= vld_d;
        data_q <= data_d;
      end
    end

`ifdef BARREL_COUT_EN
    always_comb begin
      cout_d = cout_q;
      if (adv && src_vld) begin
        if (src_rem[0]) begin
          cout_d = move_cout(src_data, src_op[0], MOVE);
        end else begin
          cout_d = src_cout;
        end
      end else begin
        cout_d = cout_q;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cout_q <= 1'b0;
      end else begin
        cout_q <= cout_d;
      end
    end
`endif

    // The final stage needs no op/amount/sign: nothing downstream consumes them.
    if (k < SHW - 1) begin : g_meta
      logic [SHW-k-2:0] rem_d, rem_q;
      logic [1:0]       op_d, op_q;
      logic             sign_d, sign_q;

      always_comb begin
        rem_d  = rem_q;
        op_d   = op_q;
        sign_d = sign_q;
        if (adv && src_vld) begin
          rem_d  = src_rem[SHW-k-1:1];
          op_d   = src_op;
          sign_d = src_sign;
        end else begin
          rem_d  = rem_q;
          op_d   = op_q;
          sign_d = sign_q;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rem_q  <= {(SHW-k-1){1'b0}};
          op_q   <= 2'b00;
          sign_q <= 1'b0;
        end else begin
          rem_q  <= rem_d;
          op_q   <= op_d;
          sign_q <= sign_d;
        end
      end
    end
  end

  assign out_valid = g_stage[SHW-1].vld_q;
  assign out_data  = g_stage[SHW-1].data_q;
`ifdef BARREL_COUT_EN
  assign out_cout  = g_stage[SHW-1].cout_q;
`endif

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Directed bench for barrel_shift_pipe at WIDTH=8: vector table, streaming, stall and reset sequences.
module tb_barrel_shift_pipe;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_amt;
  logic [1:0] in_op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
`ifdef BARREL_COUT_EN
  logic       out_cout;
`endif

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [1:0] op;
    logic [2:0] amt;
    logic [7:0] din;
    logic [7:0] dout;
    logic       cout;
  } vec_t;

  vec_t       vecs[16];
  logic [8:0] exp_q[$];

  barrel_shift_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef BARREL_COUT_EN
    .out_cout  (out_cout),
`endif
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Bit-by-bit reference: returns {cout, data}.
  function automatic logic [8:0] ref_model(input logic [1:0] op, input logic [2:0] amt,
                                           input logic [7:0] d);
    logic [7:0] r;
    logic       c;
    int         a;
    a = int'(amt);
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      case (op)
        2'b00:   r[3'((i + a) % 8)] = d[i];
        2'b01:   r[3'((i + 8 - a) % 8)] = d[i];
        2'b10:   if (i + a < 8) r[3'(i + a)] = d[i];
        default: if (i - a >= 0) r[3'(i - a)] = d[i];
      endcase
    end
    if (op == 2'b11) begin
      for (int i = 8 - a; i < 8; i++) r[3'(i)] = d[7];
    end
    if (a == 0) c = 1'b0;
    else if (op[0]) c = d[3'(a - 1)];
    else c = d[3'(8 - a)];
    return {c, r};
  endfunction

  // Single op into an idle pipe; expects the result exactly three cycles later.
  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    @(negedge clk);
    in_valid = 1'b1; in_op = v.op; in_amt = v.amt; in_data = v.din;
    @(negedge clk);
    in_valid = 1'b0; in_data = 8'h5A; in_amt = 3'd5; in_op = 2'b01;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'd3);
    check({tag, "_data"}, 32'(out_data), 32'(v.dout));
`ifdef BARREL_COUT_EN
    check({tag, "_cout"}, 32'(out_cout), 32'(v.cout));
`endif
  endtask

  // Three ops into a stalled pipe; leaves the caller at the first cycle out_valid is seen.
  task automatic fill_stalled(input string tag);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check({tag, "_in_ready_fill"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_op    = 2'(c + 1);
      in_amt   = 3'(2 * c + 1);
      in_data  = 8'(8'hC3 + 8'(c * 17));
      exp_q.push_back(ref_model(in_op, in_amt, in_data));
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [8:0] e;
    int         got;

    vecs[0]  = '{2'b00, 3'd1, 8'h81, 8'h03, 1'b1};
    vecs[1]  = '{2'b01, 3'd3, 8'h01, 8'h20, 1'b0};
    vecs[2]  = '{2'b10, 3'd4, 8'hFF, 8'hF0, 1'b1};
    vecs[3]  = '{2'b11, 3'd7, 8'h80, 8'hFF, 1'b0};
    vecs[4]  = '{2'b11, 3'd7, 8'h7F, 8'h00, 1'b1};
    vecs[5]  = '{2'b00, 3'd0, 8'hA5, 8'hA5, 1'b0};
    vecs[6]  = '{2'b01, 3'd0, 8'hA5, 8'hA5, 1'b0};
    vecs[7]  = '{2'b10, 3'd0, 8'hA5, 8'hA5, 1'b0};
    vecs[8]  = '{2'b11, 3'd0, 8'hA5, 8'hA5, 1'b0};
    vecs[9]  = '{2'b00, 3'd4, 8'h96, 8'h69, 1'b1};
    vecs[10] = '{2'b01, 3'd2, 8'h3C, 8'h0F, 1'b0};
    vecs[11] = '{2'b10, 3'd7, 8'h01, 8'h80, 1'b0};
    vecs[12] = '{2'b11, 3'd2, 8'hB4, 8'hED, 1'b0};
    vecs[13] = '{2'b01, 3'd1, 8'h01, 8'h80, 1'b1};
    vecs[14] = '{2'b10, 3'd1, 8'h81, 8'h02, 1'b1};
    vecs[15] = '{2'b11, 3'd6, 8'h40, 8'h01, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_amt = 3'd0; in_op = 2'b00;
    out_ready = 1'b1;
    #7;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
`ifdef BARREL_COUT_EN
    check("reset_out_cout", 32'(out_cout), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Eight ops back to back: results must occupy exactly cycles 3..10, in order.
    @(negedge clk);
    for (int c = 0; c < 14; c++) begin
      check("b2b_valid", 32'(out_valid), 32'(c >= 3 && c < 11));
      check("b2b_in_ready", 32'(in_ready), 32'd1);
      if (out_valid) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("b2b_data", 32'(out_data), 32'(e[7:0]));
`ifdef BARREL_COUT_EN
          check("b2b_cout", 32'(out_cout), 32'(e[8]));
`endif
        end else begin
          check("b2b_extra_result", 32'(out_data), 32'hDEAD);
        end
      end
      if (c < 8) begin
        in_valid = 1'b1;
        in_op    = 2'(c % 4);
        in_amt   = 3'((c * 3 + 1) % 8);
        in_data  = 8'((c + 1) * 53);
        exp_q.push_back(ref_model(in_op, in_amt, in_data));
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure: head result must sit still for five cycles, then all three drain.
    fill_stalled("bp");
    e = exp_q[0];
    for (int s = 0; s < 5; s++) begin
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data_stable", 32'(out_data), 32'(e[7:0]));
      @(negedge clk);
    end
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid && out_ready) begin
        got++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("bp_drain_data", 32'(out_data), 32'(e[7:0]));
        end else begin
          check("bp_extra_result", 32'(out_data), 32'hDEAD);
        end
      end
      @(negedge clk);
    end
    check("bp_drain_count", 32'(got), 32'd3);

    // Reset while the pipe is full and stalled: outputs drop at once, nothing stale reappears.
    fill_stalled("rst");
    check("rst_full_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(out_valid), 32'd0);
    check("rst_async_data", 32'(out_data), 32'd0);
`ifdef BARREL_COUT_EN
    check("rst_async_cout", 32'(out_cout), 32'd0);
`endif
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      check("rst_no_stale", 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    run_vec(vecs[0], "post_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
